alignment_collector: RTL and testbench

Receive side of the accelerator's alignment output stream. Captures the per-cycle traceback letters (query/database letter plus gap flag) while `output_valid` is high, together with the final score. Reverses the traceback order into forward alignment order in an internal LIFO, then drains it to a host-facing valid/ready stream. Sits between the accelerator top and the host/test interface.

---
 rtl/design_variables.sv | 14 +
 rtl/align_lifo.sv | 48 ++++
 rtl/alignment_collector.sv | 114 +++++++++++
 tb/tb_alignment_collector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/design_variables.sv
// design_variables: shared accelerator constants plus the alignment collector's state type.
package design_variables;
    localparam int LETTER_WIDTH  = 2;
    localparam int SEQ_LENGTH    = 32;
    localparam int SCORE_WIDTH   = 10;
    localparam int ALIGN_DEPTH   = 2 * SEQ_LENGTH;
    localparam int ALIGN_DEPTH_W = $clog2(ALIGN_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } collect_state_e;
endpackage

// File: rtl/align_lifo.sv
// align_lifo: register stack with synchronous clear; pushes beyond DEPTH are dropped.
module align_lifo #(
    parameter int W     = 6,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [W-1:0]               top,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          wr_en;
    logic [AW-1:0] wr_idx, rd_idx;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign top   = mem_q[rd_idx];

    always_comb begin
        wr_en   = push && !full && !clear;
        wr_idx  = AW'(count_q);
        rd_idx  = AW'(count_q - CW'(1));
        count_d = clear ? '0 :
                  wr_en ? count_q + CW'(1) :
                  (pop && !empty) ? count_q - CW'(1) : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    // Storage needs no reset: nothing is ever read above count_q.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= din;
    end
endmodule

// File: rtl/alignment_collector.sv
// alignment_collector: captures traceback symbols into a LIFO and replays them
// in forward alignment order on a valid/ready stream.
module alignment_collector
    import design_variables::*;
#(
    parameter int LETTER_WIDTH = design_variables::LETTER_WIDTH,
    parameter int SEQ_LENGTH   = design_variables::SEQ_LENGTH,
    parameter int SCORE_WIDTH  = design_variables::SCORE_WIDTH,
    parameter int DEPTH        = 2 * SEQ_LENGTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       output_valid,
    input  logic [LETTER_WIDTH:0]      query_seq_out,
    input  logic [LETTER_WIDTH:0]      database_seq_out,
    input  logic [SCORE_WIDTH-1:0]     score,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [LETTER_WIDTH:0]      m_query,
    output logic [LETTER_WIDTH:0]      m_database,
    output logic                       m_last,
    output logic [$clog2(DEPTH+1)-1:0] align_len,
    output logic [SCORE_WIDTH-1:0]     align_score,
    output logic                       busy,
    output logic                       overflow
);
    localparam int SW = LETTER_WIDTH + 1;
    localparam int CW = $clog2(DEPTH + 1);

    collect_state_e           state_q, state_d;
    logic [CW-1:0]            len_q, len_d;
    logic [SCORE_WIDTH-1:0]   score_q, score_d;
    logic                     ovf_q, ovf_d;
    logic                     clear, push, pop, full, empty;
    logic [CW-1:0]            count;
    logic [2*SW-1:0]          top;

    align_lifo #(.W(2 * SW), .DEPTH(DEPTH)) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   ({query_seq_out, database_seq_out}),
        .count (count),
        .top   (top),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            score_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            score_q <= score_d;
            ovf_q   <= ovf_d;
        end
    end

    // start outranks everything, including a symbol offered in the same cycle.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        score_d = score_q;
        ovf_d   = ovf_q;
        clear   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        if (start) begin
            state_d = CAPTURE;
            len_d   = '0;
            score_d = '0;
            ovf_d   = 1'b0;
            clear   = 1'b1;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (output_valid) begin
                        push  = 1'b1;
                        ovf_d = ovf_q | full;
                    end else if (!empty) begin
                        score_d = score;
                        len_d   = count;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_valid && m_ready) begin
                        pop     = 1'b1;
                        state_d = (count == CW'(1)) ? IDLE : DRAIN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_valid     = (state_q == DRAIN) && !empty;
        m_query     = m_valid ? top[2*SW-1:SW] : '0;
        m_database  = m_valid ? top[SW-1:0] : '0;
        m_last      = m_valid && (count == CW'(1));
        align_len   = len_q;
        align_score = score_q;
        busy        = state_q != IDLE;
        overflow    = ovf_q;
    end
endmodule

// File: tb/tb_alignment_collector.sv
// tb_alignment_collector: scoreboard bench; expected forward-order symbols are queued
// when a stream is driven and popped on every host handshake.
module tb_alignment_collector;
    localparam int LW    = 2;
    localparam int SCW   = 10;
    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            output_valid = 1'b0;
    logic [LW:0]     query_seq_out = '0;
    logic [LW:0]     database_seq_out = '0;
    logic [SCW-1:0]  score = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [LW:0]     m_query;
    logic [LW:0]     m_database;
    logic            m_last;
    logic [CW-1:0]   align_len;
    logic [SCW-1:0]  align_score;
    logic            busy;
    logic            overflow;

    int total = 0;
    int bad = 0;
    logic [6:0] exp_q[$];
    logic       stall;
    logic [6:0] held;

    alignment_collector dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .output_valid     (output_valid),
        .query_seq_out    (query_seq_out),
        .database_seq_out (database_seq_out),
        .score            (score),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_query          (m_query),
        .m_database       (m_database),
        .m_last           (m_last),
        .align_len        (align_len),
        .align_score      (align_score),
        .busy             (busy),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Symbol generator: low 3 bits query, high 3 bits database.
    function automatic logic [5:0] sym(input int i, input int salt, input bit gap);
        logic [5:0] s;
        s = (salt == 0) ? {3'(i), 3'(~i)} : 6'((i * 7 + salt * 13) ^ (i >> 2));
        return gap ? (s | 6'b100100) : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [6:0] e;
        if (rst_n && m_valid) begin
            if (stall) check("hold", {m_query, m_database, m_last}, held);
            if (m_ready) begin
                if (exp_q.size() == 0) check("extra_symbol", {m_query, m_database, m_last}, 7'h7f);
                else begin
                    e = exp_q.pop_front();
                    check("symbol", {m_query, m_database, m_last}, e);
                end
            end
        end
        stall = rst_n && m_valid && !m_ready;
        held  = {m_query, m_database, m_last};
    end

    task automatic pulse_start();
        m_ready = 1'b0;
        start = 1'b1;
        exp_q.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input int n, input int salt, input bit gap, input int sc);
        int kept;
        logic [5:0] s;
        for (int i = 0; i < n; i++) begin
            s = sym(i, salt, gap);
            output_valid = 1'b1;
            query_seq_out = s[2:0];
            database_seq_out = s[5:3];
            tick();
        end
        output_valid = 1'b0;
        score = SCW'(sc);
        kept = (n < DEPTH) ? n : DEPTH;
        for (int i = kept - 1; i >= 0; i--) begin
            s = sym(i, salt, gap);
            exp_q.push_back({s[2:0], s[5:3], i == 0});
        end
        tick();
        score = '0;
    endtask

    task automatic drain(input bit toggle, output int cyc);
        logic [3:0] pat;
        pat = 4'b1001;
        cyc = 0;
        while (busy && cyc < 1000) begin
            m_ready = toggle ? pat[cyc % 4] : 1'b1;
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        check("drain_busy", busy, 0);
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        #2;
        check("rst_valid", m_valid, 0);
        check("rst_outs", {m_query, m_database, m_last, busy, overflow}, 0);
        check("rst_len", align_len, 0);
        check("rst_score", align_score, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic 5-symbol alignment at full throughput.
        pulse_start();
        check("t1_busy", busy, 1);
        stream(5, 0, 0, 17);
        check("t1_valid", m_valid, 1);
        check("t1_len", align_len, 5);
        check("t1_score", align_score, 17);
        drain(0, cyc);
        check("t1_cycles", cyc, 5);
        check("t1_len_hold", align_len, 5);

        // Same stream with backpressure.
        pulse_start();
        check("t2_len_clr", align_len, 0);
        stream(5, 0, 0, 17);
        drain(1, cyc);
        check("t2_score_hold", align_score, 17);

        // Overflow.
        pulse_start();
        stream(DEPTH + 3, 1, 0, 300);
        check("t3_ovf", overflow, 1);
        check("t3_len", align_len, DEPTH);
        check("t3_score", align_score, 300);
        drain(0, cyc);
        check("t3_cycles", cyc, DEPTH);

        // Abort mid-drain with 3 symbols left.
        pulse_start();
        check("t4_ovf_clr", overflow, 0);
        stream(5, 2, 0, 9);
        m_ready = 1'b1;
        tick();
        tick();
        check("t4_remaining", exp_q.size(), 3);
        pulse_start();
        check("t4_valid", m_valid, 0);
        check("t4_len", align_len, 0);
        check("t4_busy", busy, 1);
        stream(2, 3, 0, 4);
        check("t4_len2", align_len, 2);
        drain(0, cyc);

        // Gap symbols round-trip; start with a simultaneous symbol is ignored.
        output_valid = 1'b1;
        query_seq_out = 3'b011;
        database_seq_out = 3'b011;
        pulse_start();
        output_valid = 1'b0;
        stream(4, 0, 1, 33);
        check("t5_len", align_len, 4);
        drain(0, cyc);

        // Reset mid-capture, then output_valid without start is ignored.
        pulse_start();
        output_valid = 1'b1;
        query_seq_out = 3'b101;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_outs", {m_valid, m_query, m_database, m_last, overflow}, 0);
        check("t6_rst_len", align_len, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        output_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_idle_busy", busy, 0);
            check("t6_idle_valid", m_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
